// File: rtl/press_cmd_pkg.sv
// Shared opcodes, FSM state encoding and response constants for the
// pressure command processor.
package press_cmd_pkg;

  typedef enum logic [7:0] {
    OP_READ_P  = 8'h01,
    OP_WR_OFS  = 8'h02,
    OP_WR_GAIN = 8'h03,
    OP_RD_OFS  = 8'h04,
    OP_RD_GAIN = 8'h05
  } opcode_t;

  typedef enum logic [2:0] {
    IDLE,
    CONV,
    CALC,
    SEND,
    GAP
  } state_t;

  localparam logic [15:0] ACK      = 16'hA5A5;
  localparam logic [15:0] NAK      = 16'hEEEE;
  localparam logic [15:0] TMO      = 16'hDEAD;
  localparam logic [15:0] GAIN_RST = 16'h0100;

endpackage

// File: rtl/press_cmd_proc_if.sv
// Command/response and sensor-conversion signals between the command
// processor (slave) and its environment (master).
interface press_cmd_proc_if;
  logic [23:0] cmd;
  logic        cmd_rdy;
  logic [15:0] tx_data;
  logic        trmt;
  logic        conv_req;
  logic        conv_done;
  logic [15:0] raw_press;
  logic        cmd_ovr;

  modport master (
    output cmd, cmd_rdy, conv_done, raw_press,
    input  tx_data, trmt, conv_req, cmd_ovr
  );

  modport slave (
    input  cmd, cmd_rdy, conv_done, raw_press,
    output tx_data, trmt, conv_req, cmd_ovr
  );
endinterface

// File: rtl/press_calc.sv
// Combinational calibration: raw x gain (Q8.8), plus signed offset,
// saturated to an unsigned 16-bit result.
module press_calc (
  input  logic [15:0] raw,
  input  logic [15:0] gain,
  input  logic [15:0] offset,
  output logic [15:0] result
);
  logic [31:0] prod;
  logic [23:0] scaled;
  logic [25:0] sum;

  always_comb begin
    prod   = {16'b0, raw} * {16'b0, gain};
    scaled = prod[31:8];
    // Two guard bits keep the largest scaled+offset clear of the sign bit.
    sum    = {2'b00, scaled} + {{10{offset[15]}}, offset};
    if (sum[25]) begin
      result = '0;
    end else if (|sum[24:16]) begin
      result = '1;
    end else begin
      result = sum[15:0];
    end
  end
endmodule

// File: rtl/press_cmd_proc.sv
// Executes 24-bit commands: calibrated pressure reads and gain/offset
// register access, returning a 16-bit response word per command.
module press_cmd_proc
  import press_cmd_pkg::*;
#(
  parameter int unsigned TX_GAP       = 1100,
  parameter int unsigned CONV_TIMEOUT = 4096
) (
  input logic             clk,
  input logic             rst_n,
  press_cmd_proc_if.slave bus
);
  localparam int unsigned CNT_MAX = (TX_GAP > CONV_TIMEOUT) ? TX_GAP : CONV_TIMEOUT;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] TMO_CNT  = CNT_W'(CONV_TIMEOUT);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(TX_GAP - 1);

  state_t           state;
  opcode_t          op;
  logic [CNT_W-1:0] cnt;
  logic [15:0]      gain;
  logic [15:0]      offset;
  logic [15:0]      raw_q;
  logic [15:0]      calc_res;

  always_comb op = opcode_t'(bus.cmd[23:16]);

  press_calc u_calc (
    .raw    (raw_q),
    .gain   (gain),
    .offset (offset),
    .result (calc_res)
  );

  // Outputs are set on the edge entering the state they belong to, so
  // trmt is high exactly during SEND and conv_req during the first CONV cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      cnt          <= '0;
      gain         <= GAIN_RST;
      offset       <= '0;
      raw_q        <= '0;
      bus.tx_data  <= '0;
      bus.trmt     <= 1'b0;
      bus.conv_req <= 1'b0;
      bus.cmd_ovr  <= 1'b0;
    end else begin
      bus.trmt     <= 1'b0;
      bus.conv_req <= 1'b0;
      bus.cmd_ovr  <= bus.cmd_rdy && (state != IDLE);

      case (state)
        IDLE: begin
          if (bus.cmd_rdy) begin
            if (op == OP_READ_P) begin
              state        <= CONV;
              cnt          <= '0;
              bus.conv_req <= 1'b1;
            end else begin
              state    <= SEND;
              bus.trmt <= 1'b1;
              case (op)
                OP_WR_OFS: begin
                  offset      <= bus.cmd[15:0];
                  bus.tx_data <= ACK;
                end
                OP_WR_GAIN: begin
                  gain        <= bus.cmd[15:0];
                  bus.tx_data <= ACK;
                end
                OP_RD_OFS:  bus.tx_data <= offset;
                OP_RD_GAIN: bus.tx_data <= gain;
                default:    bus.tx_data <= NAK;
              endcase
            end
          end
        end

        CONV: begin
          if (bus.conv_done) begin
            raw_q <= bus.raw_press;
            state <= CALC;
          end else if (cnt == TMO_CNT) begin
            state       <= SEND;
            bus.trmt    <= 1'b1;
            bus.tx_data <= TMO;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        CALC: begin
          state       <= SEND;
          bus.trmt    <= 1'b1;
          bus.tx_data <= calc_res;
        end

        SEND: begin
          state <= GAP;
          cnt   <= '0;
        end

        GAP: begin
          if (cnt == GAP_LAST) begin
            state <= IDLE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        default: state <= IDLE;
      endcase
    end
  end
endmodule
